// File: rtl/com_if.sv
// Bus bundle for the 1-bit comparator "com": operands, clear and the registered results.
// Optional feature macro: COM_MISMATCH_CNT_EN adds the mismatch_cnt signal.
interface com_if #(
  parameter int CNT_W = 8
);

  // Legal counter widths are 2..16. Anything else stops elaboration here.
  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("com_if: CNT_W must be in 2..16");
  end

  logic a;
  logic b;
  logic clr;
  logic c;
  logic gt;
  logic lt;
  logic mismatch_seen;
`ifdef COM_MISMATCH_CNT_EN
  logic [CNT_W-1:0] mismatch_cnt;
`endif

  // The stimulus side drives the operands and the clear, and observes the results.
  modport master (
    output a, b, clr,
    input  c, gt, lt, mismatch_seen
`ifdef COM_MISMATCH_CNT_EN
    , input mismatch_cnt
`endif
  );

  // The comparator itself receives the operands and the clear, and drives the results.
  modport slave (
    input  a, b, clr,
    output c, gt, lt, mismatch_seen
`ifdef COM_MISMATCH_CNT_EN
    , output mismatch_cnt
`endif
  );

endinterface

// File: rtl/com.sv
// com: registered 1-bit magnitude comparator with a sticky mismatch flag.
// Optional feature macro: COM_MISMATCH_CNT_EN adds a saturating mismatch counter.
// rst_n is synchronous and active-low. No output has a combinational path from rst_n.
module com #(
  parameter int CNT_W = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  com_if.slave  bus
);

  // Legal counter widths are 2..16. Anything else stops elaboration here.
  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("com: CNT_W must be in 2..16");
  end

  logic c_q;
  logic gt_q;
  logic lt_q;
  logic seen_q;
  logic mismatch;

  assign mismatch = bus.a ^ bus.b;

  // Compare result register. The reset value reads as "equal" so that exactly one flag is high.
  // clr has no effect on this register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q  <= 1'b1;
      gt_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      c_q  <= ~mismatch;
      gt_q <= bus.a & ~bus.b;
      lt_q <= ~bus.a & bus.b;
    end
  end

  // Sticky mismatch flag. When clr arrives on the same edge as a mismatch, clr wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
    end else if (bus.clr) begin
      seen_q <= 1'b0;
    end else if (mismatch) begin
      seen_q <= 1'b1;
    end
  end

  assign bus.c             = c_q;
  assign bus.gt            = gt_q;
  assign bus.lt            = lt_q;
  assign bus.mismatch_seen = seen_q;

`ifdef COM_MISMATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_full;

  assign cnt_full = &cnt_q;

  // Mismatch counter. It saturates at all-ones instead of wrapping, and clr has priority over counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.clr) begin
      cnt_q <= '0;
    end else if (mismatch && !cnt_full) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.mismatch_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_com.sv
// Bench for com. It applies directed vectors whose expected results were worked out by hand.
// Each vector pushes its expected result into a queue. A separate monitor pops and checks that
// result one half-cycle after the edge that registered it.
// The counter checks are included only when COM_MISMATCH_CNT_EN is defined.
module tb_com;

  localparam int CNT_W = 2;

  typedef struct {
    string            name;
    logic             c;
    logic             gt;
    logic             lt;
    logic             seen;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  exp_t exp_q[$];
  int   vectors_applied;
  int   comparisons;
  int   miscompares;

  com_if #(.CNT_W(CNT_W)) bus ();

  com #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against its required value and records the outcome.
  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
    comparisons++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  // Drives one vector on the falling edge. After the rising edge registers it, the task queues the
  // response expected from that edge.
  task automatic applyStimulus(input string name, input logic r, input logic a, input logic b,
                               input logic clr, input logic ec, input logic egt, input logic elt,
                               input logic eseen, input logic [CNT_W-1:0] ecnt);
    exp_t e;
    @(negedge clk);
    rst_n   = r;
    bus.a   = a;
    bus.b   = b;
    bus.clr = clr;
    @(posedge clk);
    e.name = name;
    e.c    = ec;
    e.gt   = egt;
    e.lt   = elt;
    e.seen = eseen;
    e.cnt  = ecnt;
    exp_q.push_back(e);
    vectors_applied++;
  endtask

  // Monitor: at every falling edge, check the oldest outstanding expected response.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({e.name, "/c"}, {15'd0, bus.c}, {15'd0, e.c});
      checkOutput({e.name, "/gt"}, {15'd0, bus.gt}, {15'd0, e.gt});
      checkOutput({e.name, "/lt"}, {15'd0, bus.lt}, {15'd0, e.lt});
      checkOutput({e.name, "/seen"}, {15'd0, bus.mismatch_seen}, {15'd0, e.seen});
      checkOutput({e.name, "/onehot"}, 16'(int'(bus.c) + int'(bus.gt) + int'(bus.lt)), 16'd1);
`ifdef COM_MISMATCH_CNT_EN
      checkOutput({e.name, "/cnt"}, 16'(bus.mismatch_cnt), 16'(e.cnt));
`endif
    end
  end

  // Hard time limit, so that a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run still active, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus. Argument order: name, rst_n, a, b, clr, then the expected c, gt, lt, seen, cnt.
  initial begin
    int wait_cycles;
    vectors_applied = 0;
    comparisons     = 0;
    miscompares     = 0;
    rst_n   = 1'b0;
    bus.a   = 1'b1;
    bus.b   = 1'b0;
    bus.clr = 1'b0;

    // Hold reset for two cycles while driving a mismatch. The outputs must show the reset values.
    applyStimulus("rst0", 0, 1, 0, 0, 1, 0, 0, 0, 2'd0);
    applyStimulus("rst1", 0, 1, 0, 0, 1, 0, 0, 0, 2'd0);

    // Walk the truth table. The counter reaches 3.
    applyStimulus("tt00",  1, 0, 0, 0, 1, 0, 0, 0, 2'd0);
    applyStimulus("tt01",  1, 0, 1, 0, 0, 0, 1, 1, 2'd1);
    applyStimulus("tt10",  1, 1, 0, 0, 0, 1, 0, 1, 2'd2);
    applyStimulus("tt11",  1, 1, 1, 0, 1, 0, 0, 1, 2'd2);
    applyStimulus("tt00b", 1, 0, 0, 0, 1, 0, 0, 1, 2'd2);
    applyStimulus("tt01b", 1, 0, 1, 0, 0, 0, 1, 1, 2'd3);

    // Clear, then hold a=1 b=0. The counter saturates at 3 and must not wrap.
    applyStimulus("clr_a", 1, 1, 1, 1, 1, 0, 0, 0, 2'd0);
    applyStimulus("sat1",  1, 1, 0, 0, 0, 1, 0, 1, 2'd1);
    applyStimulus("sat2",  1, 1, 0, 0, 0, 1, 0, 1, 2'd2);
    applyStimulus("sat3",  1, 1, 0, 0, 0, 1, 0, 1, 2'd3);
    applyStimulus("sat4",  1, 1, 0, 0, 0, 1, 0, 1, 2'd3);
    applyStimulus("sat5",  1, 1, 0, 0, 0, 1, 0, 1, 2'd3);
    applyStimulus("sat6",  1, 1, 0, 0, 0, 1, 0, 1, 2'd3);

    // Build the count up to 2. Then a clr on the same edge as a mismatch must leave the count at 0,
    // while lt still follows the inputs.
    applyStimulus("clr_b",  1, 0, 0, 1, 1, 0, 0, 0, 2'd0);
    applyStimulus("pre1",   1, 1, 0, 0, 0, 1, 0, 1, 2'd1);
    applyStimulus("pre2",   1, 1, 0, 0, 0, 1, 0, 1, 2'd2);
    applyStimulus("clr_mm", 1, 0, 1, 1, 0, 0, 1, 0, 2'd0);

    // Build the count up to 3, then apply reset for one cycle in mid-stream.
    applyStimulus("up1",   1, 0, 1, 0, 0, 0, 1, 1, 2'd1);
    applyStimulus("up2",   1, 0, 1, 0, 0, 0, 1, 1, 2'd2);
    applyStimulus("up3",   1, 0, 1, 0, 0, 0, 1, 1, 2'd3);
    applyStimulus("midrst", 0, 1, 0, 0, 1, 0, 0, 0, 2'd0);
    applyStimulus("post11", 1, 1, 1, 0, 1, 0, 0, 0, 2'd0);

    // Reset takes priority over clr and over input sampling.
    applyStimulus("pre_r",  1, 0, 1, 0, 0, 0, 1, 1, 2'd1);
    applyStimulus("rst_clr", 0, 0, 1, 1, 1, 0, 0, 0, 2'd0);
    applyStimulus("post01", 1, 0, 1, 0, 0, 0, 1, 1, 2'd1);
    applyStimulus("clr_eq", 1, 0, 0, 1, 1, 0, 0, 0, 2'd0);

    // Wait, with a cycle limit, for the monitor to check everything still queued.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d responses left unchecked, required 0", exp_q.size());
    end
    @(posedge clk);

    $display("[TB] %0d individual comparisons made", comparisons);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
